// File: rtl/hamming_scrub_pkg.sv
// Shared types for the hamming register scrub controller.
// Holds the scrub FSM encoding and the pass counter width.
package hamming_scrub_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, WRITE} scrub_state_t;

  localparam int PASS_CNT_W = 16;

endpackage

// File: rtl/hamming_scrub_ctrl.sv
// Periodic scrubber and host arbiter for a hamming_reg bank; host ack 1 cycle after accept.
// Backpressure: host holds host_req until host_ack (1 access per 2 cycles); host wins the write port.
module hamming_scrub_ctrl
  import hamming_scrub_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REGS     = 4,
  parameter int SCRUB_PERIOD = 1024,
  localparam int ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           scrub_en,
  input  logic                           host_req,
  input  logic                           host_we,
  input  logic [ADDR_W-1:0]              host_addr,
  input  logic [DATA_WIDTH-1:0]          host_wdata,
  output logic                           host_ack,
  output logic [DATA_WIDTH-1:0]          host_rdata,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] bank_rdata,
  output logic [NUM_REGS-1:0]            bank_wren,
  output logic [DATA_WIDTH-1:0]          bank_wdata,
  output logic                           scrub_busy,
  output logic                           pass_done,
  output logic [PASS_CNT_W-1:0]          pass_count
);

  localparam int                   TIMER_W      = $clog2(SCRUB_PERIOD + 1);
  localparam logic [TIMER_W-1:0]   TIMER_RELOAD = TIMER_W'(SCRUB_PERIOD - 1);
  localparam logic [ADDR_W-1:0]    LAST_IDX     = ADDR_W'(NUM_REGS - 1);
  localparam logic [NUM_REGS-1:0]  ONE_LSB      = NUM_REGS'(1);

  scrub_state_t          state, state_nxt;
  logic [TIMER_W-1:0]    timer;
  logic [ADDR_W-1:0]     idx;
  logic [DATA_WIDTH-1:0] scrub_buf;
  logic                  wb_pend;

  logic                  host_acc, host_wr, host_hit;
  logic                  scrub_wr, step_done;
  logic [NUM_REGS-1:0]   wren_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic [DATA_WIDTH-1:0] rd_idx, rd_host;

  assign host_acc = host_req && !host_ack;
  assign host_wr  = host_acc && host_we;
  assign host_hit = host_wr && (host_addr == idx);
  assign rd_idx   = bank_rdata[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
  assign rd_host  = bank_rdata[int'(host_addr)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (scrub_en) state_nxt = WAIT;
      WAIT:    if (!scrub_en) state_nxt = IDLE;
               else if (timer == '0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = host_hit ? WAIT : WRITE;
      WRITE:   if (wb_pend || host_hit) state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  // wb_pend marks the cycle the scrub pulse is on the bank; the step retires after it.
  always_comb begin
    scrub_wr  = (state == WRITE) && !wb_pend && !host_wr;
    step_done = ((state == CAPTURE || state == WRITE) && host_hit) ||
                (state == WRITE && wb_pend);
    wren_nxt  = '0;
    wdata_nxt = '0;
    if (host_wr) begin
      wren_nxt  = ONE_LSB << host_addr;
      wdata_nxt = host_wdata;
    end else if (scrub_wr) begin
      wren_nxt  = ONE_LSB << idx;
      wdata_nxt = scrub_buf;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= TIMER_RELOAD;
      idx        <= '0;
      scrub_buf  <= '0;
      wb_pend    <= 1'b0;
      scrub_busy <= 1'b0;
      pass_done  <= 1'b0;
      pass_count <= '0;
    end else begin
      state      <= state_nxt;
      scrub_busy <= (state_nxt == CAPTURE) || (state_nxt == WRITE);
      wb_pend    <= scrub_wr;
      pass_done  <= 1'b0;
      if (state == WAIT && state_nxt == WAIT) timer <= timer - 1'b1;
      else                                    timer <= TIMER_RELOAD;
      // A host write landing on idx this cycle is not yet in rdata; take it from the write port.
      if (state == CAPTURE) scrub_buf <= bank_wren[idx] ? bank_wdata : rd_idx;
      if (step_done) begin
        if (idx == LAST_IDX) begin
          idx       <= '0;
          pass_done <= 1'b1;
          if (pass_count != '1) pass_count <= pass_count + 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_ack   <= 1'b0;
      host_rdata <= '0;
      bank_wren  <= '0;
      bank_wdata <= '0;
    end else begin
      host_ack   <= host_acc;
      host_rdata <= (host_acc && !host_we) ? rd_host : '0;
      bank_wren  <= wren_nxt;
      bank_wdata <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed and randomized bench for hamming_scrub_ctrl with a behavioural register bank.
// Scrub timing is predicted arithmetically: PERIOD wait cycles, capture, write, pulse.
module tb_hamming_scrub_ctrl;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int PER = 4;

  logic          clk = 1'b0;
  logic          reset, scrub_en, host_req, host_we;
  logic [1:0]    host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic [NR*DW-1:0] bank_rdata;
  logic [NR-1:0] bank_wren;
  logic [DW-1:0] bank_wdata;
  logic          scrub_busy, pass_done;
  logic [15:0]   pass_count;

  always #5 clk = ~clk;

  hamming_scrub_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR), .SCRUB_PERIOD(PER)) dut (
    .clk(clk), .reset(reset), .scrub_en(scrub_en),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .bank_rdata(bank_rdata), .bank_wren(bank_wren), .bank_wdata(bank_wdata),
    .scrub_busy(scrub_busy), .pass_done(pass_done), .pass_count(pass_count)
  );

  // Bank stand-in: bank_val is the corrected value, bank_err the raw upset mask.
  logic [DW-1:0] bank_val [NR];
  logic [DW-1:0] bank_err [NR];
  logic [DW-1:0] mdl [NR];

  for (genvar g = 0; g < NR; g++) begin : g_rd
    assign bank_rdata[g*DW +: DW] = bank_val[g];
  end

  always @(posedge clk)
    for (int i = 0; i < NR; i++)
      if (bank_wren[i]) begin
        bank_val[i] <= bank_wdata;
        bank_err[i] <= '0;
      end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            log_cyc[$];
  logic [NR-1:0] log_wren[$];
  logic [DW-1:0] log_wdata[$];
  int            multi_hot = 0;

  always @(negedge clk)
    if (reset && bank_wren != '0) begin
      log_cyc.push_back(cyc);
      log_wren.push_back(bank_wren);
      log_wdata.push_back(bank_wdata);
      if ($countones(bank_wren) > 1) multi_hot++;
    end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int i = 0; i < budget && log_cyc.size() < n; i++) step();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ack"},   host_ack,   0);
    chk({tag, "_rdata"}, host_rdata, 0);
    chk({tag, "_wren"},  bank_wren,  0);
    chk({tag, "_wdata"}, bank_wdata, 0);
    chk({tag, "_pdone"}, pass_done,  0);
    chk({tag, "_pcnt"},  pass_count, 0);
    chk({tag, "_busy"},  scrub_busy, 0);
  endtask

  int            e0, p, n0;
  logic [1:0]    ra;
  logic          rw;
  logic [DW-1:0] rd;

  initial begin
    reset = 1'b0; scrub_en = 1'b0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0;
    for (int i = 0; i < NR; i++) begin
      bank_val[i] = DW'($urandom);
      bank_err[i] = '0;
    end
    bank_val[1] = 8'h5A;
    for (int i = 0; i < NR; i++) mdl[i] = bank_val[i];

    repeat (3) step();
    chk_outputs_zero("reset");

    // Scrub sweep with no host traffic.
    reset = 1'b1; scrub_en = 1'b1; e0 = cyc + 1;
    wait_log(4, 80);
    chk("t1_nwrites", log_cyc.size(), 4);
    for (int k = 0; k < 4 && k < log_cyc.size(); k++) begin
      chk("t1_cyc",   log_cyc[k],   e0 + PER + 2 + k*(PER + 3));
      chk("t1_wren",  log_wren[k],  4'b0001 << k);
      chk("t1_wdata", log_wdata[k], mdl[k]);
    end
    for (int i = 0; i < 20 && cyc < e0 + PER + 3 + 3*(PER + 3); i++) step();
    chk("t1_pass_done", pass_done, 1);
    chk("t1_pass_count", pass_count, 1);
    step();
    chk("t1_pass_done_clr", pass_done, 0);

    // Single upset on reg 1 is repaired by its next scrub.
    bank_err[1] = 8'h04;
    wait_log(6, 60);
    chk("t2_nwrites", log_cyc.size(), 6);
    if (log_cyc.size() >= 6) begin
      chk("t2_cyc",   log_cyc[5],   e0 + PER + 2 + 5*(PER + 3));
      chk("t2_wren",  log_wren[5],  4'b0010);
      chk("t2_wdata", log_wdata[5], 8'h5A);
    end
    step();
    chk("t2_raw_clean", bank_val[1] ^ bank_err[1], 8'h5A);

    // Host write to the register being written back abandons the scrub step.
    p = e0 + PER + 2 + 6*(PER + 3);
    for (int i = 0; i < 60 && cyc < p - 1; i++) step();
    chk("t3_busy", scrub_busy, 1);
    host_req = 1'b1; host_we = 1'b1; host_addr = 2'd2; host_wdata = 8'hC3;
    step();
    chk("t3_ack", host_ack, 1);
    chk("t3_wren", bank_wren, 4'b0100);
    chk("t3_wdata", bank_wdata, 8'hC3);
    mdl[2] = 8'hC3;
    host_req = 1'b0;

    // Host write to another register stalls the scrub write by one cycle.
    for (int i = 0; i < 20 && cyc < p + 5; i++) step();
    host_req = 1'b1; host_we = 1'b1; host_addr = 2'd0; host_wdata = DW'($urandom);
    step();
    chk("t4_ack", host_ack, 1);
    chk("t4_host_wren", bank_wren, 4'b0001);
    chk("t4_host_wdata", bank_wdata, host_wdata);
    mdl[0] = host_wdata;
    host_req = 1'b0;
    step();
    chk("t4_scrub_wren", bank_wren, 4'b1000);
    chk("t4_scrub_wdata", bank_wdata, mdl[3]);
    step();
    chk("t4_pass_done", pass_done, 1);
    chk("t4_pass_count", pass_count, 2);
    chk("t34_nwrites", log_cyc.size(), 9);

    // Host read path and back-to-back request spacing.
    scrub_en = 1'b0;
    repeat (2) step();
    host_req = 1'b1; host_we = 1'b1; host_addr = 2'd1; host_wdata = 8'h77;
    step();
    chk("t5_wr_ack", host_ack, 1);
    mdl[1] = 8'h77;
    host_req = 1'b0;
    step();
    host_req = 1'b1; host_we = 1'b0; host_addr = 2'd1;
    step();
    chk("t5_ack1", host_ack, 1);
    chk("t5_rdata1", host_rdata, 8'h77);
    chk("t5_no_wren", bank_wren, 0);
    host_addr = 2'd3;
    step();
    chk("t5_ack_gap", host_ack, 0);
    step();
    chk("t5_ack2", host_ack, 1);
    chk("t5_rdata2", host_rdata, mdl[3]);
    host_req = 1'b0;
    step();

    // Random host traffic racing the scrubber; stored data must follow host writes only.
    scrub_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      ra = 2'($urandom_range(0, NR - 1));
      rw = 1'($urandom_range(0, 1));
      rd = DW'($urandom);
      host_req = 1'b1; host_we = rw; host_addr = ra; host_wdata = rd;
      step();
      chk("rnd_ack", host_ack, 1);
      if (rw) mdl[ra] = rd;
      else    chk("rnd_rdata", host_rdata, mdl[ra]);
      host_req = 1'b0;
      repeat (1 + $urandom_range(0, 3)) step();
    end
    repeat (12) step();
    for (int i = 0; i < NR; i++) chk("rnd_bank", bank_val[i], mdl[i]);
    chk("rnd_multi_hot", multi_hot, 0);

    // Reset asserted during CAPTURE.
    for (int i = 0; i < 40 && scrub_busy; i++) step();
    for (int i = 0; i < 40 && !scrub_busy; i++) step();
    chk("t6_in_capture", scrub_busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_outputs_zero("t6_async");
    step();
    reset = 1'b1; e0 = cyc + 1; n0 = log_cyc.size();
    wait_log(n0 + 1, 40);
    chk("t6_nwrites", log_cyc.size(), n0 + 1);
    if (log_cyc.size() > n0) begin
      chk("t6_cyc",   log_cyc[n0],   e0 + PER + 2);
      chk("t6_wren",  log_wren[n0],  4'b0001);
      chk("t6_wdata", log_wdata[n0], mdl[0]);
    end
    chk("t6_pass_count", pass_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
